// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: gathers operand A, operand B and an opcode from the UART
// receiver, gives the ALU one settle cycle, then hands the result to the UART
// transmitter and waits for it to finish. It adds an inter-byte timeout and
// overrun reporting.
module uart_alu_sequencer #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int NBIT_OPCODE    = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  input  logic                     tx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] alu_data_in,
  output logic [NBIT_DATA_LEN-1:0] A,
  output logic [NBIT_DATA_LEN-1:0] B,
  output logic [NBIT_OPCODE-1:0]   OPCODE,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data_out,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     rx_overrun
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    WAIT_TX
  } state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [NBIT_DATA_LEN-1:0] a_next, b_next, txd_next;
  logic [NBIT_OPCODE-1:0]   op_next;
  logic                     tx_start_next, err_next, ovr_next, busy_next;
  logic                     timeout_hit;

  // State and every output are registered; async reset clears all of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_A;
      cnt         <= '0;
      A           <= '0;
      B           <= '0;
      OPCODE      <= '0;
      tx_start    <= 1'b0;
      tx_data_out <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      A           <= a_next;
      B           <= b_next;
      OPCODE      <= op_next;
      tx_start    <= tx_start_next;
      tx_data_out <= txd_next;
      busy        <= busy_next;
      err_timeout <= err_next;
      rx_overrun  <= ovr_next;
    end
  end

  // Next-state and next-output logic; a tick on the timeout threshold wins.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    a_next        = A;
    b_next        = B;
    op_next       = OPCODE;
    txd_next      = tx_data_out;
    tx_start_next = 1'b0;
    err_next      = 1'b0;
    ovr_next      = 1'b0;
    timeout_hit   = TIMEOUT_EN && (cnt == CNT_LAST);

    case (state)
      WAIT_A: begin
        cnt_next = '0;
        if (rx_done_tick) begin
          a_next     = rx_data_in;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          b_next     = rx_data_in;
          cnt_next   = '0;
          state_next = WAIT_OP;
        end else if (timeout_hit) begin
          cnt_next   = '0;
          err_next   = 1'b1;
          state_next = WAIT_A;
        end else if (TIMEOUT_EN) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          op_next    = rx_data_in[NBIT_OPCODE-1:0];
          cnt_next   = '0;
          state_next = EXEC;
        end else if (timeout_hit) begin
          cnt_next   = '0;
          err_next   = 1'b1;
          state_next = WAIT_A;
        end else if (TIMEOUT_EN) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      EXEC: begin
        txd_next      = alu_data_in;
        tx_start_next = 1'b1;
        ovr_next      = rx_done_tick;
        state_next    = WAIT_TX;
      end
      WAIT_TX: begin
        ovr_next = rx_done_tick;
        if (tx_done_tick) begin
          cnt_next   = '0;
          state_next = WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase

    busy_next = (state_next != WAIT_A);
  end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Clocked controller that sequences the UART-to-ALU datapath. It collects three received bytes as operand A, operand B and OPCODE, then waits one cycle for the combinational ALU to settle. It captures the ALU result, starts the UART transmitter, and waits for transmission to finish before accepting the next operation. It sits between the UART RX/TX pair and the ALU, and adds an inter-byte timeout and overrun reporting.

## Interface

Parameters:
- NBIT_DATA_LEN, 8, width of UART bytes, operands and ALU result
- NBIT_OPCODE, 6, ALU opcode width; taken from the low bits of the third byte
- TIMEOUT_CYCLES, 100000, maximum idle cycles allowed between bytes of one operation; 0 disables the timeout

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  reset; one clock; asynchronous, active-high
- rx_done_tick  in  1  one-cycle pulse: rx_data_in holds a new byte
- rx_data_in  in  NBIT_DATA_LEN  received byte
- tx_done_tick  in  1  one-cycle pulse: transmitter finished its byte
- alu_data_in  in  NBIT_DATA_LEN  combinational ALU result
- A  out  NBIT_DATA_LEN  registered operand A to ALU
- B  out  NBIT_DATA_LEN  registered operand B to ALU
- OPCODE  out  NBIT_OPCODE  registered opcode to ALU
- tx_start  out  1  one-cycle pulse that starts the transmitter
- tx_data_out  out  NBIT_DATA_LEN  registered byte to transmit (captured ALU result)
- busy  out  1  high whenever state is not WAIT_A
- err_timeout  out  1  one-cycle pulse: operation aborted by the inter-byte timeout
- rx_overrun  out  1  one-cycle pulse: a byte arrived while the block was not accepting bytes

## Operation

- All outputs are registered. Reset value of every output register is 0; state resets to WAIT_A and the timeout counter to 0.
- States and transitions:
  - WAIT_A: on rx_done_tick, A <= rx_data_in, go to WAIT_B.
  - WAIT_B: on rx_done_tick, B <= rx_data_in, go to WAIT_OP.
  - WAIT_OP: on rx_done_tick, OPCODE <= rx_data_in[NBIT_OPCODE-1:0], go to EXEC. Upper bits are discarded.
  - EXEC: unconditionally tx_data_out <= alu_data_in and tx_start <= 1, go to WAIT_TX. This is a settle cycle: the ALU sees the new OPCODE for one full cycle before capture.
  - WAIT_TX: on tx_done_tick, go to WAIT_A.
- A, B and OPCODE hold their values until overwritten. They are not cleared on timeout or on return to WAIT_A.
- Timeout:
  - The counter clears on every accepted byte and on entry to WAIT_A.
  - It increments each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done_tick in that cycle, the next state is WAIT_A and err_timeout pulses for one cycle.
  - If a tick and the timeout threshold coincide, the tick wins: the byte is accepted and there is no error.
  - With TIMEOUT_CYCLES = 0 the counter is held at 0 and no timeout ever fires.
- Overrun: an rx_done_tick in EXEC or WAIT_TX is dropped. The byte is not stored, there is no state change, and rx_overrun pulses in the following cycle.
- tx_done_tick outside WAIT_TX is ignored.
- Reset mid-operation: all registers return to reset values asynchronously. A tx_start pulse in flight is cut to 0 immediately.

## Timing

- Edge numbering: the opcode rx_done_tick is sampled at edge k.
  - OPCODE is valid after edge k.
  - tx_data_out and tx_start=1 are valid after edge k+1.
  - tx_start returns to 0 after edge k+2.
- tx_start is high for exactly one cycle per operation. It is never asserted twice without an intervening tx_done_tick.
- Latency from the third-byte tick to tx_start = 2 cycles.
- Latency from tx_done_tick (sampled at edge m) to readiness = 0: a byte ticked at edge m+1 is accepted as the next A.
- A tick sampled at the same edge as the tx_done_tick (in WAIT_TX) is an overrun.
- busy is high after edge n for the A tick sampled at edge n, and low after the edge that returns to WAIT_A.
- err_timeout and rx_overrun are high for exactly one cycle per event.
- Back-to-back ticks on consecutive cycles in WAIT_A/WAIT_B/WAIT_OP are each accepted.

## Test plan

- Basic op: ticks with 0x05, 0x03, 0x20; bench ALU model returns A+B → A=0x05, B=0x03, OPCODE=0x20, tx_data_out=0x08, one tx_start pulse 2 cycles after the third tick. After tx_done_tick, busy=0.
- Opcode truncation and consecutive ticks: bytes 0xFF, 0x01, 0xE2 on three consecutive cycles → OPCODE=0x22, all three accepted, tx_start 2 cycles after the last byte.
- Timeout, with TIMEOUT_CYCLES=10:
  - A=0x11, then no byte for 10 cycles → err_timeout pulse once, state WAIT_A, A still 0x11.
  - Next three bytes 0x02, 0x02, 0x20 → normal operation with tx_data_out=0x04.
- Timeout boundary: tick for B arriving on the threshold cycle → accepted, no err_timeout.
- Overrun: a byte 0x7F during WAIT_TX → rx_overrun pulse, A/B/OPCODE unchanged, no extra tx_start. After tx_done_tick the next byte 0x09 becomes A.
- Async reset during WAIT_OP, and separately in the tx_start cycle → all outputs 0 immediately. A fresh three-byte sequence then completes normally.
